uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_pkg.sv | 17 +
 rtl/uart_tx_arbiter_if.sv | 39 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 117 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit arbiter slice.
//   N_DEF   : default number of requesters
//   W_DEF   : default data word width
//   state_t : arbiter FSM state encoding
package uart_pkg;

   localparam int N_DEF = 4;
   localparam int W_DEF = 8;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_START     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bus between N requesters, the arbiter and the shared serializer.
//   req      : per-requester request level
//   data     : packed request words, requester i at [i*W +: W]
//   ack      : one-hot capture pulse back to the requesters
//   tx_data  : word handed to the serializer
//   tx_start : one-cycle start strobe to the serializer
//   tx_busy  : serializer busy flag
// master = arbiter side, slave = requester/serializer side.
interface uart_tx_arbiter_if import uart_pkg::*; #(
   parameter int N = N_DEF,
   parameter int W = W_DEF
);

   logic [N-1:0]   req;
   logic [N*W-1:0] data;
   logic [N-1:0]   ack;
   logic [W-1:0]   tx_data;
   logic           tx_start;
   logic           tx_busy;

   modport master (
      input  req,
      input  data,
      input  tx_busy,
      output ack,
      output tx_data,
      output tx_start
   );

   modport slave (
      output req,
      output data,
      output tx_busy,
      input  ack,
      input  tx_data,
      input  tx_start
   );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational rotating-priority picker.
//   req   : request vector
//   ptr   : last served index; search starts at ptr+1 and wraps at N-1
//   valid : at least one request is pending
//   index : winning requester (0 when nothing is pending)
module rr_pick import uart_pkg::*; #(
   parameter  int N  = N_DEF,
   localparam int GW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [GW-1:0] ptr,
   output logic          valid,
   output logic [GW-1:0] index
);

   // Scan offsets from farthest to nearest so the requester closest after ptr has the last word.
   always_comb begin
      int sum_v;
      int cand_v;
      valid = 1'b0;
      index = '0;
      sum_v = 0;
      cand_v = 0;
      for (int i = N; i >= 1; i--) begin
         sum_v  = int'(ptr) + i;
         // ptr < N and i <= N, so one subtraction wraps into 0..N-1 for any N.
         cand_v = (sum_v >= N) ? (sum_v - N) : sum_v;
         index  = req[cand_v] ? GW'(cand_v) : index;
         valid  = valid | req[cand_v];
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one external UART serializer from N requesters.
//   clock    : rising-edge clock
//   reset    : asynchronous active-high reset
//   bus      : requester/serializer bus (master side)
//   grant_id : index of the current or last granted requester
//   active   : high whenever the FSM is not idle
//   error    : one-cycle pulse when the serializer never went busy
// A word is captured in S_IDLE, strobed in S_START, and the FSM then waits for
// the serializer to go busy (bounded by BusyTimeout) and to finish.
module uart_tx_arbiter import uart_pkg::*; #(
   parameter  int N           = N_DEF,
   parameter  int W           = W_DEF,
   parameter  int BusyTimeout = 3,
   localparam int GW          = (N > 1) ? $clog2(N) : 1
) (
   input  logic               clock,
   input  logic               reset,
   uart_tx_arbiter_if.master  bus,
   output logic [GW-1:0]      grant_id,
   output logic               active,
   output logic               error
);

   localparam int CW = (BusyTimeout > 1) ? $clog2(BusyTimeout + 1) : 1;

   state_t        state_r;
   logic [GW-1:0] ptr_r;
   logic [GW-1:0] grant_id_r;
   logic [W-1:0]  tx_data_r;
   logic [N-1:0]  ack_r;
   logic          tx_start_r;
   logic          error_r;
   logic [CW-1:0] cnt_r;

   logic          pick_valid_s;
   logic [GW-1:0] pick_idx_s;
   logic [W-1:0]  pick_data_s;
   logic [N-1:0]  pick_onehot_s;

   rr_pick #(.N(N)) u_rr_pick (
      .req   (bus.req),
      .ptr   (ptr_r),
      .valid (pick_valid_s),
      .index (pick_idx_s)
   );

   // Winner's word and one-hot ack, ready to be latched on the grant edge.
   always_comb begin
      pick_data_s   = bus.data[pick_idx_s*W +: W];
      pick_onehot_s = {{(N-1){1'b0}}, 1'b1} << pick_idx_s;
   end

   // Arbiter FSM; strobes default low so ack/tx_start/error are single-cycle pulses.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r    <= S_IDLE;
         ptr_r      <= GW'(N - 1);
         grant_id_r <= '0;
         tx_data_r  <= '0;
         ack_r      <= '0;
         tx_start_r <= 1'b0;
         error_r    <= 1'b0;
         cnt_r      <= '0;
      end else begin
         ack_r      <= '0;
         tx_start_r <= 1'b0;
         error_r    <= 1'b0;
         case (state_r)
            S_IDLE: begin
               // Strobes are set here so they are high during the S_START cycle.
               if (pick_valid_s) begin
                  tx_data_r  <= pick_data_s;
                  grant_id_r <= pick_idx_s;
                  ack_r      <= pick_onehot_s;
                  tx_start_r <= 1'b1;
                  state_r    <= S_START;
               end
            end
            S_START: begin
               cnt_r   <= CW'(BusyTimeout);
               state_r <= S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
               if (bus.tx_busy) begin
                  state_r <= S_WAIT_DONE;
               end else if (cnt_r <= CW'(1)) begin
                  // Counter reaches zero on this decrement: give up, drop the word.
                  cnt_r   <= '0;
                  error_r <= 1'b1;
                  ptr_r   <= grant_id_r;
                  state_r <= S_IDLE;
               end else begin
                  cnt_r <= cnt_r - CW'(1);
               end
            end
            S_WAIT_DONE: begin
               // Return to idle only; the next grant needs one more edge.
               if (!bus.tx_busy) begin
                  ptr_r   <= grant_id_r;
                  state_r <= S_IDLE;
               end
            end
            default: begin
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.ack      = ack_r;
   assign bus.tx_data  = tx_data_r;
   assign bus.tx_start = tx_start_r;
   assign grant_id     = grant_id_r;
   assign active       = (state_r != S_IDLE);
   assign error        = error_r;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench: a 4-requester arbiter and a 3-requester arbiter, each with
// a simple serializer model that holds tx_busy for a fixed frame length.
module tb_uart_tx_arbiter;

   logic clock = 1'b0;
   logic reset = 1'b1;

   logic [1:0] grant_id_a;
   logic       active_a;
   logic       error_a;
   logic [1:0] grant_id_b;
   logic       active_b;
   logic       error_b;

   bit ser_mute_a = 1'b0;
   int ser_cnt_a;
   int ser_cnt_b;

   int err_cnt = 0;
   int chk_cnt = 0;

   int g_q[$];
   int d_q[$];

   uart_tx_arbiter_if #(.N(4), .W(8)) bus_a ();
   uart_tx_arbiter_if #(.N(3), .W(8)) bus_b ();

   uart_tx_arbiter #(.N(4), .W(8), .BusyTimeout(3)) dut_a (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus_a),
      .grant_id (grant_id_a),
      .active   (active_a),
      .error    (error_a)
   );

   uart_tx_arbiter #(.N(3), .W(8), .BusyTimeout(3)) dut_b (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus_b),
      .grant_id (grant_id_b),
      .active   (active_b),
      .error    (error_b)
   );

   always #5 clock = ~clock;

   // Serializer model A: busy for 10 cycles after each start unless muted.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         bus_a.tx_busy <= 1'b0;
         ser_cnt_a     <= 0;
      end else if (bus_a.tx_start && !ser_mute_a) begin
         bus_a.tx_busy <= 1'b1;
         ser_cnt_a     <= 10;
      end else if (ser_cnt_a > 1) begin
         ser_cnt_a <= ser_cnt_a - 1;
      end else begin
         ser_cnt_a     <= 0;
         bus_a.tx_busy <= 1'b0;
      end
   end

   // Serializer model B: busy for 4 cycles after each start.
   always @(posedge clock or posedge reset) begin
      if (reset) begin
         bus_b.tx_busy <= 1'b0;
         ser_cnt_b     <= 0;
      end else if (bus_b.tx_start) begin
         bus_b.tx_busy <= 1'b1;
         ser_cnt_b     <= 4;
      end else if (ser_cnt_b > 1) begin
         ser_cnt_b <= ser_cnt_b - 1;
      end else begin
         ser_cnt_b     <= 0;
         bus_b.tx_busy <= 1'b0;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      chk_cnt++;
      if (obs !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Collect nwords grants on DUT A; requesters in drop_mask release req after their ack.
   task automatic collect_a(input int nwords, input logic [3:0] drop_mask, input int budget);
      int got = 0;
      int cyc = 0;
      while (got < nwords && cyc < budget) begin
         @(negedge clock);
         cyc++;
         if (bus_a.ack != 4'b0000) begin
            g_q.push_back(int'(grant_id_a));
            d_q.push_back(int'(bus_a.tx_data));
            check_eq("ack_onehot", 32'(bus_a.ack), 32'(4'b0001 << grant_id_a));
            check_eq("start_with_ack", 32'(bus_a.tx_start), 32'd1);
            bus_a.req = bus_a.req & ~(bus_a.ack & drop_mask);
            got++;
         end
      end
      check_eq("words_seen", 32'(got), 32'(nwords));
   endtask

   task automatic wait_idle_a(input int budget);
      int cyc = 0;
      do begin
         @(negedge clock);
         cyc++;
      end while (active_a && cyc < budget);
      check_eq("idle_reached", 32'(active_a), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_d[4];
      int n;
      int got;
      int cyc;
      bit seen3;
      exp_d = '{32'h10, 32'h21, 32'h32, 32'h43};

      bus_a.req  = 4'b0000;
      bus_a.data = {8'h43, 8'h32, 8'h21, 8'h10};
      bus_b.req  = 3'b000;
      bus_b.data = {8'hC2, 8'hB1, 8'hA0};

      // Reset state
      repeat (3) @(negedge clock);
      check_eq("rst_tx_data", 32'(bus_a.tx_data), 32'h00);
      check_eq("rst_grant_id", 32'(grant_id_a), 32'd0);
      check_eq("rst_tx_start", 32'(bus_a.tx_start), 32'd0);
      check_eq("rst_ack", 32'(bus_a.ack), 32'd0);
      check_eq("rst_error", 32'(error_a), 32'd0);
      check_eq("rst_active", 32'(active_a), 32'd0);

      // All four request: served 0,1,2,3 with their own words
      reset     = 1'b0;
      bus_a.req = 4'b1111;
      collect_a(4, 4'b1111, 200);
      for (int i = 0; i < 4; i++) begin
         check_eq($sformatf("rr_grant%0d", i), 32'(g_q[i]), 32'(i));
         check_eq($sformatf("rr_data%0d", i), 32'(d_q[i]), 32'(exp_d[i]));
      end
      wait_idle_a(40);

      // req[2] held, req[0] raised while 2 is being sent: 2, then 0, then 2
      g_q.delete();
      d_q.delete();
      bus_a.req = 4'b0100;
      collect_a(1, 4'b0000, 20);
      bus_a.req[0] = 1'b1;
      collect_a(2, 4'b0001, 100);
      check_eq("hold_first", 32'(g_q[0]), 32'd2);
      check_eq("hold_second", 32'(g_q[1]), 32'd0);
      check_eq("hold_third", 32'(g_q[2]), 32'd2);
      check_eq("hold_data", 32'(d_q[1]), 32'h10);
      bus_a.req = 4'b0000;
      wait_idle_a(40);

      // Serializer never goes busy: error BusyTimeout+1 cycles after tx_start
      g_q.delete();
      d_q.delete();
      ser_mute_a = 1'b1;
      bus_a.req  = 4'b1010;
      collect_a(1, 4'b1000, 20);
      check_eq("to_grant", 32'(g_q[0]), 32'd3);
      n = 0;
      while (!error_a && n < 20) begin
         @(negedge clock);
         n++;
      end
      check_eq("to_latency", 32'(n), 32'd4);
      check_eq("to_idle", 32'(active_a), 32'd0);
      @(negedge clock);
      check_eq("to_pulse_width", 32'(error_a), 32'd0);
      check_eq("to_next_ack", 32'(bus_a.ack), 32'b0010);
      check_eq("to_next_grant", 32'(grant_id_a), 32'd1);
      ser_mute_a   = 1'b0;
      bus_a.req[1] = 1'b0;
      wait_idle_a(40);

      // Reset while the serializer is still busy
      g_q.delete();
      d_q.delete();
      bus_a.req = 4'b1000;
      collect_a(1, 4'b1000, 20);
      check_eq("mid_grant", 32'(g_q[0]), 32'd3);
      repeat (3) @(negedge clock);
      check_eq("mid_active", 32'(active_a), 32'd1);
      reset = 1'b1;
      #1;
      check_eq("mid_tx_data", 32'(bus_a.tx_data), 32'h00);
      check_eq("mid_grant_id", 32'(grant_id_a), 32'd0);
      check_eq("mid_tx_start", 32'(bus_a.tx_start), 32'd0);
      check_eq("mid_ack", 32'(bus_a.ack), 32'd0);
      check_eq("mid_error", 32'(error_a), 32'd0);
      check_eq("mid_rst_active", 32'(active_a), 32'd0);
      bus_a.req = 4'b0100;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_eq("post_rst_ack", 32'(bus_a.ack), 32'b0100);
      check_eq("post_rst_grant", 32'(grant_id_a), 32'd2);
      check_eq("post_rst_data", 32'(bus_a.tx_data), 32'h32);
      check_eq("post_rst_error", 32'(error_a), 32'd0);
      bus_a.req = 4'b0000;
      wait_idle_a(40);

      // N=3, requesters 0 and 2 held for six words
      g_q.delete();
      bus_b.req = 3'b101;
      got   = 0;
      cyc   = 0;
      seen3 = 1'b0;
      while (got < 6 && cyc < 300) begin
         @(negedge clock);
         cyc++;
         if (grant_id_b == 2'd3) seen3 = 1'b1;
         if (bus_b.ack != 3'b000) begin
            g_q.push_back(int'(grant_id_b));
            got++;
         end
      end
      check_eq("n3_words", 32'(got), 32'd6);
      for (int i = 0; i < 6; i++) begin
         check_eq($sformatf("n3_grant%0d", i), 32'(g_q[i]), (i % 2 == 0) ? 32'd0 : 32'd2);
      end
      check_eq("n3_no_index3", 32'(seen3), 32'd0);
      bus_b.req = 3'b000;

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
